// File: rtl/hs_trailer_detector.sv
`default_nettype none
// ============================================================================
// Module   : hs_trailer_detector
// Brief    : Multi-lane HS trailer detector: per-lane run-length tracking,
//            trailer completion flag and payload-break indication.
// Revision : 1.0
// ============================================================================
module hs_trailer_detector #(
  parameter int LANES     = 2,
  parameter int SPC       = 2,
  parameter int CNT_W     = 8,
  parameter int BREAK_MIN = 2
) (
  input  logic                   clk_comparator,
  input  logic                   RST,
  input  logic                   comparator_enable,
  input  logic [LANES*SPC-1:0]   hs_rx_data,
  input  logic [LANES-1:0]       lane_mask,
  input  logic [CNT_W-1:0]       trail_len,
  output logic [LANES-1:0]       lane_done,
  output logic                   trailer_done,
  output logic [LANES-1:0]       trailer_level,
  output logic                   break_pulse,
  output logic                   break_seen
);

  localparam logic [CNT_W:0]   c_spc_ext     = (CNT_W+1)'(SPC);
  localparam logic [CNT_W:0]   c_cnt_max_ext = {1'b0, {CNT_W{1'b1}}};
  localparam logic [CNT_W-1:0] c_cnt_max     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_break_min   = CNT_W'(BREAK_MIN);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt [LANES];
  logic [LANES-1:0] r_ref;
  logic [LANES-1:0] r_mask;
  logic [LANES-1:0] r_lane_done;
  logic [CNT_W-1:0] r_len;
  logic             r_trailer_done;
  logic             r_break_pulse;
  logic             r_break_seen;

  logic             w_entering;
  logic [LANES-1:0] w_mask_eff;
  logic [CNT_W-1:0] w_len_eff;
  logic             w_all_done;
  logic [CNT_W-1:0] w_nxt_cnt [LANES];
  logic [LANES-1:0] w_nxt_ref;
  logic [LANES-1:0] w_nxt_done;
  logic [LANES-1:0] w_brk;

  // Next run length: extend the run if the whole word matches the previous
  // level, otherwise restart with the trailing run ending at the newest sample.
  function automatic logic [CNT_W-1:0] f_next_cnt(
    input logic [SPC-1:0]   smp,
    input logic             ref_in,
    input logic [CNT_W-1:0] cnt_in
  );
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] run;
    logic             stop;
    sum  = '0;
    run  = '0;
    stop = 1'b0;
    if (smp == {SPC{ref_in}}) begin
      sum        = {1'b0, cnt_in} + c_spc_ext;
      f_next_cnt = (sum > c_cnt_max_ext) ? c_cnt_max : sum[CNT_W-1:0];
    end else begin
      for (int i = SPC-1; i >= 0; i--) begin
        if (!stop && (smp[i] == smp[SPC-1])) begin
          run = run + c_cnt_one;
        end else begin
          stop = 1'b1;
        end
      end
      f_next_cnt = run;
    end
  endfunction

  // On the window-opening edge the live mask/length and a zero history apply.
  assign w_entering = (r_state == S_IDLE);
  assign w_mask_eff = w_entering ? lane_mask : r_mask;
  assign w_len_eff  = w_entering ? ((trail_len == '0) ? c_cnt_one : trail_len) : r_len;
  assign w_all_done = (|r_mask) && (&(r_lane_done | ~r_mask));

  always_comb begin
    w_nxt_ref  = '0;
    w_nxt_done = '0;
    w_brk      = '0;
    for (int l = 0; l < LANES; l++) begin
      w_nxt_cnt[l] = '0;
      if (w_mask_eff[l]) begin
        w_nxt_cnt[l]  = f_next_cnt(hs_rx_data[l*SPC +: SPC],
                                   w_entering ? 1'b0 : r_ref[l],
                                   w_entering ? '0 : r_cnt[l]);
        w_nxt_ref[l]  = hs_rx_data[l*SPC + SPC - 1];
        w_nxt_done[l] = (w_nxt_cnt[l] >= w_len_eff);
        w_brk[l]      = !w_entering
                        && (hs_rx_data[l*SPC +: SPC] != {SPC{r_ref[l]}})
                        && (r_cnt[l] >= c_break_min);
      end
    end
  end

  always_ff @(posedge clk_comparator or negedge RST) begin
    if (!RST) begin
      r_state        <= S_IDLE;
      for (int l = 0; l < LANES; l++) r_cnt[l] <= '0;
      r_ref          <= '0;
      r_mask         <= '0;
      r_len          <= '0;
      r_lane_done    <= '0;
      r_trailer_done <= 1'b0;
      r_break_pulse  <= 1'b0;
      r_break_seen   <= 1'b0;
    end else if (!comparator_enable) begin
      r_state        <= S_IDLE;
      for (int l = 0; l < LANES; l++) r_cnt[l] <= '0;
      r_ref          <= '0;
      r_lane_done    <= '0;
      r_trailer_done <= 1'b0;
      r_break_pulse  <= 1'b0;
      r_break_seen   <= 1'b0;
    end else begin
      r_break_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state     <= S_SEARCH;
          r_mask      <= lane_mask;
          r_len       <= w_len_eff;
          for (int l = 0; l < LANES; l++) r_cnt[l] <= w_nxt_cnt[l];
          r_ref       <= w_nxt_ref;
          r_lane_done <= w_nxt_done;
        end
        S_SEARCH: begin
          if (w_all_done) begin
            r_state        <= S_DONE;
            r_trailer_done <= 1'b1;
          end else begin
            for (int l = 0; l < LANES; l++) r_cnt[l] <= w_nxt_cnt[l];
            r_ref         <= w_nxt_ref;
            r_lane_done   <= w_nxt_done;
            r_break_pulse <= |w_brk;
            r_break_seen  <= r_break_seen | (|w_brk);
          end
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign lane_done     = r_lane_done;
  assign trailer_done  = r_trailer_done;
  assign trailer_level = r_ref;
  assign break_pulse   = r_break_pulse;
  assign break_seen    = r_break_seen;

endmodule
`default_nettype wire

// File: tb/tb_hs_trailer_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_hs_trailer_detector
// Brief    : Directed self-checking bench for hs_trailer_detector (8-bit and
//            4-bit counter instances).
// Revision : 1.0
// ============================================================================
module tb_hs_trailer_detector;

  logic clk_comparator = 1'b0;
  logic RST;
  always #5 clk_comparator = ~clk_comparator;

  int n_vec = 0;
  int n_err = 0;

  logic       a_en, b_en;
  logic [3:0] a_data, b_data;
  logic [1:0] a_mask, b_mask;
  logic [7:0] a_len;
  logic [3:0] b_len;
  logic [1:0] a_ldone, a_level, b_ldone, b_level;
  logic       a_tdone, a_bp, a_bs, b_tdone, b_bp, b_bs;
  logic       bp_any, ld_any;

  hs_trailer_detector #(.LANES(2), .SPC(2), .CNT_W(8), .BREAK_MIN(2)) u_dut_a (
    .clk_comparator    (clk_comparator),
    .RST               (RST),
    .comparator_enable (a_en),
    .hs_rx_data        (a_data),
    .lane_mask         (a_mask),
    .trail_len         (a_len),
    .lane_done         (a_ldone),
    .trailer_done      (a_tdone),
    .trailer_level     (a_level),
    .break_pulse       (a_bp),
    .break_seen        (a_bs)
  );

  hs_trailer_detector #(.LANES(2), .SPC(2), .CNT_W(4), .BREAK_MIN(2)) u_dut_b (
    .clk_comparator    (clk_comparator),
    .RST               (RST),
    .comparator_enable (b_en),
    .hs_rx_data        (b_data),
    .lane_mask         (b_mask),
    .trail_len         (b_len),
    .lane_done         (b_ldone),
    .trailer_done      (b_tdone),
    .trailer_level     (b_level),
    .break_pulse       (b_bp),
    .break_seen        (b_bs)
  );

  task automatic tick();
    @(posedge clk_comparator);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b0; a_en = 1'b0; a_data = '0; a_mask = '0; a_len = '0;
    b_en = 1'b0; b_data = '0; b_mask = '0; b_len = '0;
    bp_any = 1'b0; ld_any = 1'b0;
    tick(); tick();
    chk("reset_a", {a_ldone, a_tdone, a_level, a_bp, a_bs}, 0);
    chk("reset_b", {b_ldone, b_tdone, b_level, b_bp, b_bs}, 0);
    RST = 1'b1;
    tick();

    // Basic trailer: lane0 constant 1, lane1 constant 0, length 10
    a_mask = 2'b11; a_len = 8'd10; a_data = 4'b0011; a_en = 1'b1; bp_any = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); bp_any |= a_bp; end
    chk("basic_ldone_e4", a_ldone, 2'b00);
    tick(); bp_any |= a_bp;
    chk("basic_ldone_e5", a_ldone, 2'b11);
    chk("basic_tdone_e5", a_tdone, 1'b0);
    tick(); bp_any |= a_bp;
    chk("basic_tdone_e6", a_tdone, 1'b1);
    chk("basic_level", a_level, 2'b01);
    chk("basic_no_break", {bp_any, a_bs}, 2'b00);
    a_en = 1'b0; tick();
    chk("basic_disable", {a_ldone, a_tdone, a_level, a_bp, a_bs}, 0);

    // Break: lane0 run of 4 then pair (old 1, new 0)
    a_en = 1'b1; a_data = 4'b0011;
    tick(); tick();
    chk("brk_pre", a_bp, 1'b0);
    a_data = 4'b0001; tick();
    chk("brk_pulse", {a_bp, a_bs}, 2'b11);
    chk("brk_level", a_level, 2'b00);
    a_data = 4'b0000; tick();
    chk("brk_pulse_clear", {a_bp, a_bs}, 2'b01);
    tick();
    chk("brk_lane1_done", a_ldone, 2'b10);
    tick(); tick();
    chk("brk_lane0_cnt9", a_ldone, 2'b10);
    tick();
    chk("brk_lane0_cnt11", a_ldone, 2'b11);
    tick();
    chk("brk_tdone_sticky", {a_tdone, a_bs}, 2'b11);
    a_en = 1'b0; tick();
    chk("brk_disable", {a_ldone, a_tdone, a_level, a_bp, a_bs}, 0);

    // Short runs: both lanes toggle every sample
    a_data = 4'b1001; a_en = 1'b1; bp_any = 1'b0; ld_any = 1'b0;
    for (int i = 0; i < 8; i++) begin tick(); bp_any |= a_bp; ld_any |= |a_ldone; end
    chk("short_no_break", {bp_any, a_bs}, 2'b00);
    chk("short_no_done", ld_any, 1'b0);
    chk("short_level", a_level, 2'b10);
    a_en = 1'b0; tick();

    // Mask: only lane0 counts; lane1 run then toggle must not break
    a_mask = 2'b01; a_len = 8'd6; a_data = 4'b0011; a_en = 1'b1; bp_any = 1'b0;
    tick(); bp_any |= a_bp;
    tick(); bp_any |= a_bp;
    a_data = 4'b1111; tick(); bp_any |= a_bp;
    chk("mask_ldone_e3", {a_ldone, a_tdone}, 3'b010);
    tick(); bp_any |= a_bp;
    chk("mask_tdone_e4", {a_ldone, a_tdone}, 3'b011);
    a_data = 4'b0011; tick(); bp_any |= a_bp;
    tick(); bp_any |= a_bp;
    chk("mask_done_hold", a_tdone, 1'b1);
    chk("mask_no_break", {bp_any, a_bs}, 2'b00);
    a_en = 1'b0; tick();

    // Abort: enable drops on the edge completion would occur
    a_mask = 2'b11; a_len = 8'd10; a_data = 4'b0011; a_en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("abort_ldone_e5", a_ldone, 2'b11);
    a_en = 1'b0; tick();
    chk("abort_idle_wins", {a_ldone, a_tdone, a_level, a_bp, a_bs}, 0);

    // Asynchronous reset mid-window with a pulse in flight
    a_en = 1'b1; a_data = 4'b0011;
    tick(); tick();
    a_data = 4'b0001; tick();
    chk("rst_pre_pulse", a_bp, 1'b1);
    #2 RST = 1'b0;
    #1 chk("rst_async", {a_ldone, a_tdone, a_level, a_bp, a_bs}, 0);
    #2 RST = 1'b1;
    a_data = 4'b0000; tick();
    chk("rst_release", {a_ldone, a_tdone, a_level, a_bp, a_bs}, 0);
    a_en = 1'b0; tick();

    // Zero length on 4-bit counters: treated as 1
    b_mask = 2'b11; b_len = 4'd0; b_data = 4'b0011; b_en = 1'b1;
    tick();
    chk("zl_first_edge", b_ldone, 2'b11);
    tick();
    chk("zl_tdone", b_tdone, 1'b1);
    b_en = 1'b0; tick();
    chk("zl_disable", {b_ldone, b_tdone, b_level, b_bp, b_bs}, 0);

    // Saturation: 14 + 2 must clamp to 15, not wrap to 0
    b_len = 4'd15; b_en = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("sat_cnt14", b_ldone, 2'b00);
    tick();
    chk("sat_no_wrap", b_ldone, 2'b11);
    tick();
    chk("sat_tdone", b_tdone, 1'b1);
    for (int i = 0; i < 11; i++) tick();
    chk("sat_hold", {b_tdone, b_ldone, b_level}, 5'b11101);
    b_en = 1'b0; tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
